// File: rtl/impulse_pkg.sv
// Shared state encoding for the impulse burst generator and its helpers.
package impulse_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      PULSE = 3'd3,
      GAP   = 3'd4
   } state_t;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter that saturates at 1 (never wraps); load wins over dec.
// Flags are combinational decodes of the registered count.
module load_down_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset_,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] value,
   output logic         is_one,
   output logic         is_zero
);

   logic [W-1:0] count;

   always_ff @(posedge clock) begin
      if (reset_) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (dec && (count > W'(1))) begin
         count <= count - W'(1);
      end
   end

   assign is_one  = (count == W'(1));
   assign is_zero = (count == '0);

endmodule

// File: rtl/impulse_burst_generator.sv
// Fetches pulse length/gap/count over soc/eoc, then emits repeat_n pulses of numero
// cycles separated by gap_len low cycles; all outputs registered, enable only gates the next request.
module impulse_burst_generator
   import impulse_pkg::*;
#(
   parameter int W = 8,
   parameter int R = 4
) (
   input  logic         clock,
   input  logic         reset_,
   input  logic         enable,
   input  logic [W-1:0] numero,
   input  logic [W-1:0] gap_len,
   input  logic [R-1:0] repeat_n,
   output logic         soc,
   input  logic         eoc,
   output logic         out,
   output logic         busy,
   output logic         done
);

   state_t state, state_n;

   logic [W-1:0] len_q, gap_q;
   logic [W-1:0] p_src;
   logic [R-1:0] rep_eff;

   logic soc_n, out_n, done_n, cap;
   logic p_load, p_dec, g_load, g_dec, b_load, b_dec;
   logic p_one, p_zero, g_one, g_zero, b_one, b_zero;
   logic p_last, g_last, b_last;

   assign rep_eff = (repeat_n == '0) ? R'(1) : repeat_n;
   assign p_last  = p_one | p_zero;
   assign g_last  = g_one | g_zero;
   assign b_last  = b_one | b_zero;

   load_down_counter #(.W(W)) u_pcnt (
      .clock   (clock),
      .reset_  (reset_),
      .load    (p_load),
      .dec     (p_dec),
      .value   (p_src),
      .is_one  (p_one),
      .is_zero (p_zero)
   );

   load_down_counter #(.W(W)) u_gcnt (
      .clock   (clock),
      .reset_  (reset_),
      .load    (g_load),
      .dec     (g_dec),
      .value   (gap_q),
      .is_one  (g_one),
      .is_zero (g_zero)
   );

   load_down_counter #(.W(R)) u_bcnt (
      .clock   (clock),
      .reset_  (reset_),
      .load    (b_load),
      .dec     (b_dec),
      .value   (rep_eff),
      .is_one  (b_one),
      .is_zero (b_zero)
   );

   always_ff @(posedge clock) begin
      if (reset_) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      soc_n   = 1'b0;
      out_n   = 1'b0;
      done_n  = 1'b0;
      cap     = 1'b0;
      p_load  = 1'b0;
      p_dec   = 1'b0;
      p_src   = len_q;
      g_load  = 1'b0;
      g_dec   = 1'b0;
      b_load  = 1'b0;
      b_dec   = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               state_n = REQ;
               soc_n   = 1'b1;
            end
         end
         REQ: begin
            if (!eoc) begin
               state_n = WAIT;
            end else begin
               soc_n = 1'b1;
            end
         end
         WAIT: begin
            if (eoc) begin
               cap    = 1'b1;
               p_load = 1'b1;
               p_src  = numero;
               b_load = 1'b1;
               if (numero == '0) begin
                  done_n  = 1'b1;
                  soc_n   = enable;
                  state_n = enable ? REQ : IDLE;
               end else begin
                  state_n = PULSE;
               end
            end
         end
         PULSE: begin
            out_n = 1'b1;
            // out is still low on the first cycle after capture: that cycle only raises out
            if (out) begin
               if (!p_last) begin
                  p_dec = 1'b1;
               end else if (b_last) begin
                  out_n   = 1'b0;
                  done_n  = 1'b1;
                  soc_n   = enable;
                  state_n = enable ? REQ : IDLE;
               end else begin
                  b_dec = 1'b1;
                  if (gap_q != '0) begin
                     out_n   = 1'b0;
                     g_load  = 1'b1;
                     state_n = GAP;
                  end else begin
                     p_load = 1'b1;
                  end
               end
            end
         end
         GAP: begin
            if (g_last) begin
               out_n   = 1'b1;
               p_load  = 1'b1;
               state_n = PULSE;
            end else begin
               g_dec = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset_) begin
         len_q <= '0;
         gap_q <= '0;
         soc   <= 1'b0;
         out   <= 1'b0;
         done  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         if (cap) begin
            len_q <= numero;
            gap_q <= gap_len;
         end
         soc  <= soc_n;
         out  <= out_n;
         done <= done_n;
         busy <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_impulse_burst_generator.sv
// Scoreboard bench: each captured burst pushes its expected out train, popped cycle by cycle.
module tb_impulse_burst_generator;

   localparam int W = 8;
   localparam int R = 4;

   logic         clock = 1'b0;
   logic         reset_;
   logic         enable;
   logic [W-1:0] numero;
   logic [W-1:0] gap_len;
   logic [R-1:0] repeat_n;
   logic         soc;
   logic         eoc;
   logic         out;
   logic         busy;
   logic         done;

   int n_chk  = 0;
   int n_fail = 0;
   bit exp_q[$];

   always #5 clock = ~clock;

   impulse_burst_generator #(.W(W), .R(R)) dut (
      .clock    (clock),
      .reset_   (reset_),
      .enable   (enable),
      .numero   (numero),
      .gap_len  (gap_len),
      .repeat_n (repeat_n),
      .soc      (soc),
      .eoc      (eoc),
      .out      (out),
      .busy     (busy),
      .done     (done)
   );

   task automatic wait_soc();
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (soc === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL soc_request: soc=%b after 20 cycles, required 1", soc);
      end
   endtask

   // Producer side: acknowledge after 2 cycles, convert for 1 cycle, then present data.
   // Returns on the negedge just before the capture edge E.
   task automatic handshake(input logic [W-1:0] n, input logic [W-1:0] g,
                            input logic [R-1:0] r, input bit drop_in_wait);
      int reff;
      wait_soc();
      repeat (2) @(negedge clock);
      n_chk++;
      if (soc !== 1'b1) begin
         n_fail++;
         $display("FAIL soc_hold: soc=%b, required 1 while eoc high", soc);
      end
      eoc = 1'b0;
      @(negedge clock);
      n_chk++;
      if (soc !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL soc_ack: soc=%b busy=%b, required soc=0 busy=1", soc, busy);
      end
      if (drop_in_wait) enable = 1'b0;
      @(negedge clock);
      numero   = n;
      gap_len  = g;
      repeat_n = r;
      eoc      = 1'b1;
      reff = (r == '0) ? 1 : int'(r);
      if (n != '0) begin
         for (int p = 0; p < reff; p++) begin
            for (int i = 0; i < int'(n); i++) exp_q.push_back(1'b1);
            if (p < reff - 1) begin
               for (int i = 0; i < int'(g); i++) exp_q.push_back(1'b0);
            end
         end
      end
   endtask

   task automatic expect_train(input bit en_after, input int drop_k);
      bit e;
      int k = 0;
      @(negedge clock);
      numero   = W'($urandom);
      gap_len  = W'($urandom);
      repeat_n = R'($urandom);
      if (exp_q.size() == 0) begin
         n_chk++;
         if (done !== 1'b1 || out !== 1'b0 || soc !== en_after) begin
            n_fail++;
            $display("FAIL zero_len: done=%b out=%b soc=%b, required done=1 out=0 soc=%b",
                     done, out, soc, en_after);
         end
      end else begin
         n_chk++;
         if (out !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL capture_cycle: out=%b busy=%b done=%b, required 0 1 0", out, busy, done);
         end
         while (exp_q.size() > 0) begin
            @(negedge clock);
            e = exp_q.pop_front();
            n_chk++;
            if (out !== e || done !== 1'b0) begin
               n_fail++;
               $display("FAIL train[%0d]: out=%b done=%b, required out=%b done=0", k, out, done, e);
            end
            if (k == drop_k) enable = 1'b0;
            k++;
         end
         @(negedge clock);
         n_chk++;
         if (done !== 1'b1 || out !== 1'b0 || soc !== en_after) begin
            n_fail++;
            $display("FAIL burst_end: done=%b out=%b soc=%b, required done=1 out=0 soc=%b",
                     done, out, soc, en_after);
         end
      end
   endtask

   task automatic check_idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_chk++;
         if (soc !== 1'b0 || busy !== 1'b0 || out !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle[%0d]: soc=%b busy=%b out=%b done=%b, required all 0",
                     i, soc, busy, out, done);
         end
      end
   endtask

   task automatic test_reset();
      reset_ = 1'b1;
      enable = 1'b0;
      eoc    = 1'b1;
      numero = '0;
      gap_len = '0;
      repeat_n = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_chk++;
      if ({soc, out, busy, done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_state: soc,out,busy,done=%b, required 0000", {soc, out, busy, done});
      end
      reset_ = 1'b0;
      enable = 1'b1;
      wait_soc();
   endtask

   task automatic test_single_pulse();
      handshake(8'd5, 8'd0, 4'd1, 1'b0);
      expect_train(1'b1, -1);
   endtask

   task automatic test_burst();
      handshake(8'd3, 8'd2, 4'd3, 1'b0);
      expect_train(1'b1, -1);
   endtask

   task automatic test_contiguous();
      handshake(8'd4, 8'd0, 4'd2, 1'b0);
      expect_train(1'b1, -1);
      handshake(8'd6, 8'd3, 4'd0, 1'b0);
      expect_train(1'b1, -1);
      handshake(8'd255, 8'd0, 4'd1, 1'b0);
      expect_train(1'b1, -1);
   endtask

   task automatic test_numero_zero();
      handshake(8'd0, 8'd5, 4'd3, 1'b0);
      expect_train(1'b1, -1);
   endtask

   task automatic test_enable_drop();
      // drop during the second pulse of a 3-pulse burst (index 3 = first bit of pulse 2)
      handshake(8'd2, 8'd1, 4'd3, 1'b0);
      expect_train(1'b0, 3);
      check_idle();
      enable = 1'b1;
      handshake(8'd3, 8'd1, 4'd2, 1'b1);
      expect_train(1'b0, -1);
      check_idle();
   endtask

   task automatic test_reset_mid_pulse();
      enable = 1'b1;
      handshake(8'd10, 8'd0, 4'd1, 1'b0);
      @(negedge clock);
      repeat (4) @(negedge clock);
      n_chk++;
      if (out !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pulse: out=%b, required 1", out);
      end
      reset_ = 1'b1;
      @(negedge clock);
      n_chk++;
      if ({soc, out, busy, done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_mid: soc,out,busy,done=%b, required 0000", {soc, out, busy, done});
      end
      exp_q.delete();
      reset_ = 1'b0;
      enable = 1'b0;
      check_idle();
      enable = 1'b1;
      handshake(8'd2, 8'd0, 4'd1, 1'b0);
      enable = 1'b0;
      expect_train(1'b0, -1);
   endtask

   initial begin
      test_reset();
      test_single_pulse();
      test_burst();
      test_contiguous();
      test_numero_zero();
      test_enable_drop();
      test_reset_mid_pulse();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
